desc_mem_arbiter: RTL and testbench

- Shares the single-port 2048x32 descriptor RAM between two Avalon-MM masters:
  - Port A: the host/CPU.
  - Port B: the DMA descriptor fetch engine.
- Grants at most one access per cycle using round-robin arbitration.
- Drives the RAM port and returns read data to the correct requester with pipelined readdatavalid.
- Sits between the interconnect and the descriptor RAM inside q_sys.

---
 rtl/desc_mem_arbiter_if.sv | 27 ++
 rtl/desc_mem_arbiter.sv | 111 +++++++++++
 tb/tb_desc_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/desc_mem_arbiter_if.sv
// One Avalon-MM port of the descriptor RAM arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface desc_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/desc_mem_arbiter.sv
// Round-robin arbiter that shares the single-port descriptor RAM between the host (A) and the DMA fetch engine (B).
// Grant and RAM drive are combinational, and read data returns through a READ_LATENCY-deep tag pipeline.
module desc_mem_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hold,
  desc_mem_arbiter_if.slave     a,
  desc_mem_arbiter_if.slave     b,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0]     mem_readdata
);
  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e                 prio_q, prio_d;
  logic                  req_a, req_b;
  logic                  grant_a, grant_b;
  logic                  push_v;
  logic [READ_LATENCY-1:0] tag_v, tag_b;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [BE_W-1:0]       be_q;
  logic                  exit_a, exit_b;

  assign req_a = a.read | a.write;
  assign req_b = b.read | b.write;

  // Grant is suppressed while hold is high or reset is asserted, so waitrequest then equals the request.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    prio_d  = prio_q;
    if (reset_n && !hold) begin
      if (req_a && (!req_b || prio_q == PORT_A)) grant_a = 1'b1;
      else if (req_b)                            grant_b = 1'b1;
    end
    if (grant_a)      prio_d = PORT_B;
    else if (grant_b) prio_d = PORT_A;
  end

  assign a.waitrequest = req_a & ~grant_a;
  assign b.waitrequest = req_b & ~grant_b;

  // RAM port follows the winner; address and data keep their last value when idle.
  always_comb begin
    mem_address    = addr_q;
    mem_writedata  = wdata_q;
    mem_byteenable = be_q;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (grant_a) begin
      mem_address    = a.address;
      mem_writedata  = a.writedata;
      mem_byteenable = a.byteenable;
      mem_chipselect = 1'b1;
      mem_write      = a.write;
    end else if (grant_b) begin
      mem_address    = b.address;
      mem_writedata  = b.writedata;
      mem_byteenable = b.byteenable;
      mem_chipselect = 1'b1;
      mem_write      = b.write;
    end
  end

  // A read+write request is treated as a write, so it pushes no tag.
  assign push_v = (grant_a & ~a.write) | (grant_b & ~b.write);
  assign exit_a = tag_v[READ_LATENCY-1] & ~tag_b[READ_LATENCY-1];
  assign exit_b = tag_v[READ_LATENCY-1] &  tag_b[READ_LATENCY-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q          <= PORT_A;
      addr_q          <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      tag_v           <= '0;
      tag_b           <= '0;
      a.readdatavalid <= 1'b0;
      b.readdatavalid <= 1'b0;
      a.readdata      <= '0;
      b.readdata      <= '0;
    end else begin
      prio_q <= prio_d;
      if (grant_a || grant_b) begin
        addr_q  <= mem_address;
        wdata_q <= mem_writedata;
        be_q    <= mem_byteenable;
      end
      for (int i = int'(READ_LATENCY) - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_b[i] <= tag_b[i-1];
      end
      tag_v[0]        <= push_v;
      tag_b[0]        <= grant_b;
      a.readdatavalid <= exit_a;
      b.readdatavalid <= exit_b;
      if (exit_a) a.readdata <= mem_readdata;
      if (exit_b) b.readdata <= mem_readdata;
    end
  end
endmodule

// File: tb/tb_desc_mem_arbiter.sv
// Randomized bench for desc_mem_arbiter: cycle-level reference of grants, shadow RAM and expected responses.
// A second instance with READ_LATENCY=2 covers the deeper read pipeline.
module tb_desc_mem_arbiter;
  localparam int unsigned AW  = 11;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 4;
  localparam int          LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, hold, hold2, init_req;
  logic [31:0] seed;

  desc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  desc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();
  desc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a2_if ();
  desc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b2_if ();

  logic [AW-1:0] m_addr, m2_addr;
  logic          m_cs, m_we, m2_cs, m2_we;
  logic [DW-1:0] m_wd, m_rd, m2_wd, m2_rd;
  logic [BW-1:0] m_be, m2_be;

  desc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .hold(hold), .a(a_if), .b(b_if),
    .mem_address(m_addr), .mem_chipselect(m_cs), .mem_write(m_we),
    .mem_writedata(m_wd), .mem_byteenable(m_be), .mem_readdata(m_rd));

  desc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .hold(hold2), .a(a2_if), .b(b2_if),
    .mem_address(m2_addr), .mem_chipselect(m2_cs), .mem_write(m2_we),
    .mem_writedata(m2_wd), .mem_byteenable(m2_be), .mem_readdata(m2_rd));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    if (i == 5)     return 32'hDEADBEEF;
    if (i == 2047)  return 32'hFFFFFFFF;
    return (32'(i) * 32'h9E3779B1) ^ seed;
  endfunction

  // RAM with unregistered output (data valid one cycle after the address)
  logic [31:0] ram1 [2048];
  logic [31:0] rd1;
  assign m_rd = rd1;
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 2048; i++) ram1[i] <= init_val(i);
    end else if (m_cs) begin
      if (m_we) ram1[m_addr] <= merge(ram1[m_addr], m_wd, m_be);
      else      rd1 <= ram1[m_addr];
    end
  end

  // RAM with registered output (two cycles), read-only in this bench
  logic [31:0] ram2 [2048];
  logic [31:0] rd2_0, rd2_1;
  assign m2_rd = rd2_1;
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 2048; i++) ram2[i] <= 32'hA000_0000 | 32'(i);
    end else begin
      rd2_0 <= ram2[m2_addr];
      rd2_1 <= rd2_0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t        qa[$], qb[$];
  logic [31:0] shadow [2048];
  bit          prefer_b;
  logic [10:0] last_addr;
  logic [31:0] last_ra, last_rb;
  int          cyc;
  bit          st_a, st_b;

  task automatic model_reset();
    qa.delete(); qb.delete();
    prefer_b = 1'b0; last_addr = '0; last_ra = '0; last_rb = '0;
  endtask

  task automatic check_rsp(input string tag, input bit is_b, input logic vld, input logic [31:0] data);
    bit exp_v;
    logic [31:0] exp_d;
    if (!is_b) begin
      exp_v = (qa.size() > 0) && (qa[0].due == cyc);
      if (exp_v) begin exp_d = qa[0].data; void'(qa.pop_front()); last_ra = exp_d; end
      else exp_d = last_ra;
    end else begin
      exp_v = (qb.size() > 0) && (qb[0].due == cyc);
      if (exp_v) begin exp_d = qb[0].data; void'(qb.pop_front()); last_rb = exp_d; end
      else exp_d = last_rb;
    end
    check({tag, "_valid"}, 32'(vld), 32'(exp_v));
    check({tag, "_data"}, data, exp_d);
  endtask

  // One clock cycle: apply inputs after the edge, check at the falling edge, then advance the model.
  task automatic step(input logic ar, input logic aw, input logic [10:0] aad, input logic [31:0] awd,
                      input logic [3:0] abe, input logic br, input logic bw, input logic [10:0] bad,
                      input logic [31:0] bwd, input logic [3:0] bbe, input logic h);
    bit ra, rb, ga, gb;
    @(posedge clk); #1;
    cyc++;
    a_if.read = ar; a_if.write = aw; a_if.address = aad; a_if.writedata = awd; a_if.byteenable = abe;
    b_if.read = br; b_if.write = bw; b_if.address = bad; b_if.writedata = bwd; b_if.byteenable = bbe;
    hold = h;
    @(negedge clk);
    ra = ar | aw; rb = br | bw;
    ga = !h && ra && (!rb || !prefer_b);
    gb = !h && rb && (!ra || prefer_b);
    check("a_waitrequest", 32'(a_if.waitrequest), 32'(ra && !ga));
    check("b_waitrequest", 32'(b_if.waitrequest), 32'(rb && !gb));
    check("mem_chipselect", 32'(m_cs), 32'(ga || gb));
    check("mem_write", 32'(m_we), 32'((ga && aw) || (gb && bw)));
    if (ga) begin
      check("mem_address_a", 32'(m_addr), 32'(aad));
      if (aw) begin check("mem_wdata_a", m_wd, awd); check("mem_be_a", 32'(m_be), 32'(abe)); end
    end else if (gb) begin
      check("mem_address_b", 32'(m_addr), 32'(bad));
      if (bw) begin check("mem_wdata_b", m_wd, bwd); check("mem_be_b", 32'(m_be), 32'(bbe)); end
    end else begin
      check("mem_address_idle", 32'(m_addr), 32'(last_addr));
    end
    check_rsp("a_rsp", 1'b0, a_if.readdatavalid, a_if.readdata);
    check_rsp("b_rsp", 1'b1, b2_dummy(b_if.readdatavalid), b_if.readdata);
    if (ga) begin
      if (aw) shadow[aad] = merge(shadow[aad], awd, abe);
      else    qa.push_back('{cyc + LAT + 1, shadow[aad]});
      last_addr = aad; prefer_b = 1'b1;
    end else if (gb) begin
      if (bw) shadow[bad] = merge(shadow[bad], bwd, bbe);
      else    qb.push_back('{cyc + LAT + 1, shadow[bad]});
      last_addr = bad; prefer_b = 1'b0;
    end
    st_a = ra && !ga; st_b = rb && !gb;
  endtask

  function automatic logic b2_dummy(input logic v);
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
  endtask

  logic        r_ar, r_aw, r_br, r_bw;
  logic [10:0] r_aad, r_bad;
  logic [31:0] r_awd, r_bwd;
  logic [3:0]  r_abe, r_bbe;
  logic        v2 [10];
  logic [31:0] d2 [10];

  initial begin
    seed = $urandom;
    init_req = 1'b1; reset_n = 1'b0; hold = 1'b0; hold2 = 1'b0; cyc = 0;
    a_if.read = 1'b1; a_if.write = 0; a_if.address = '0; a_if.writedata = '0; a_if.byteenable = '0;
    b_if.read = 0; b_if.write = 0; b_if.address = '0; b_if.writedata = '0; b_if.byteenable = '0;
    a2_if.read = 0; a2_if.write = 0; a2_if.address = '0; a2_if.writedata = '0; a2_if.byteenable = '0;
    b2_if.read = 0; b2_if.write = 0; b2_if.address = '0; b2_if.writedata = '0; b2_if.byteenable = '0;
    for (int i = 0; i < 2048; i++) shadow[i] = init_val(i);
    model_reset();
    @(posedge clk); #1; init_req = 1'b0;
    @(negedge clk);
    check("rst_a_valid", 32'(a_if.readdatavalid), 0);
    check("rst_a_data", a_if.readdata, 0);
    check("rst_cs", 32'(m_cs), 0);
    check("rst_we", 32'(m_we), 0);
    check("rst_a_wait_eq_req", 32'(a_if.waitrequest), 1);
    #2; reset_n = 1'b1; a_if.read = 1'b0;

    // hold with both requesting, then A wins first
    for (int i = 0; i < 3; i++) step(1, 0, 11'd1, '0, '0, 1, 0, 11'd2, '0, '0, 1);
    step(1, 0, 11'd1, '0, '0, 1, 0, 11'd2, '0, '0, 0);
    check("hold_release_a_first", 32'(st_a), 0);
    step(0, 0, '0, '0, '0, 1, 0, 11'd2, '0, '0, 0);
    idle(3);

    // single A read of the preloaded word
    step(1, 0, 11'h005, '0, '0, 0, 0, '0, '0, '0, 0);
    idle(3);
    check("a_read_005", a_if.readdata, 32'hDEADBEEF);

    // partial write by A, read back by B
    step(0, 1, 11'h7FF, 32'h12345678, 4'b0011, 0, 0, '0, '0, '0, 0);
    step(0, 0, '0, '0, '0, 1, 0, 11'h7FF, '0, '0, 0);
    idle(3);
    check("b_read_7ff", b_if.readdata, 32'hFFFF5678);

    // continuous reads from both ports alternate
    r_aad = 11'd16; r_bad = 11'd32;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, r_aad, '0, '0, 1, 0, r_bad, '0, '0, 0);
      if (!st_a) r_aad = r_aad + 11'd1;
      if (!st_b) r_bad = r_bad + 11'd1;
    end
    idle(3);
    check("alt_a_count", 32'(r_aad - 11'd16), 4);
    check("alt_b_count", 32'(r_bad - 11'd32), 4);

    // randomized traffic; stalled masters keep their command
    st_a = 0; st_b = 0;
    for (int i = 0; i < 800; i++) begin
      if (!st_a) begin
        r_ar = 0; r_aw = 0;
        case ($urandom_range(0, 7))
          0, 1, 2: r_ar = 1;
          3, 4:    r_aw = 1;
          5:       begin r_ar = 1; r_aw = 1; end
          default: ;
        endcase
        r_aad = 11'($urandom_range(0, 15)); r_awd = $urandom; r_abe = 4'($urandom);
      end
      if (!st_b) begin
        r_br = 0; r_bw = 0;
        case ($urandom_range(0, 7))
          0, 1, 2: r_br = 1;
          3, 4:    r_bw = 1;
          5:       begin r_br = 1; r_bw = 1; end
          default: ;
        endcase
        r_bad = 11'($urandom_range(0, 15)); r_bwd = $urandom; r_bbe = 4'($urandom);
      end
      step(r_ar, r_aw, r_aad, r_awd, r_abe, r_br, r_bw, r_bad, r_bwd, r_bbe, ($urandom_range(0, 7) == 0));
    end
    idle(4);

    // reset right after a B read is accepted discards it
    step(0, 0, '0, '0, '0, 1, 0, 11'd9, '0, '0, 0);
    @(posedge clk); #1;
    b_if.read = 0; a_if.read = 1'b1; reset_n = 1'b0;
    #1;
    check("mid_rst_b_valid", 32'(b_if.readdatavalid), 0);
    check("mid_rst_b_data", b_if.readdata, 0);
    check("mid_rst_a_data", a_if.readdata, 0);
    check("mid_rst_cs", 32'(m_cs), 0);
    check("mid_rst_a_wait", 32'(a_if.waitrequest), 1);
    model_reset();
    @(negedge clk); reset_n = 1'b1; a_if.read = 1'b0;
    idle(4);

    // READ_LATENCY=2: four back-to-back B reads
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      b2_if.read = (k < 4); b2_if.address = 11'(k);
      @(negedge clk);
      if (k < 4) check("l2_wait", 32'(b2_if.waitrequest), 0);
      v2[k] = b2_if.readdatavalid; d2[k] = b2_if.readdata;
      check("l2_a_valid", 32'(a2_if.readdatavalid), 0);
    end
    for (int k = 0; k < 10; k++) begin
      check("l2_b_valid", 32'(v2[k]), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) check("l2_b_data", d2[k], 32'hA000_0000 | 32'(k - 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
